level_gain_apply: RTL

Applies a user-entered linear gain to the audio stream. The gain is entered as four BCD digits in the same thousandths format the level meter displays, so 1000 means unity gain. The block converts the digits to binary serially and ramps the applied gain toward the new setting one step per sample to avoid zipper noise. It sits in the channel-strip signal path ahead of the output level meter, clocked by the 48 kHz sample clock, and processes one sample per clock.

---
 rtl/level_pkg.sv | 21 ++
 rtl/gain_mult_sat.sv | 35 +++
 rtl/level_gain_apply.sv | 124 ++++++++++++
 3 files changed

// File: rtl/level_pkg.sv
// Shared types and constants for the level/gain path.
// Gains are unsigned thousandths; 1000 means unity.
package level_pkg;

  typedef logic [3:0]  bcd_t;
  typedef logic [13:0] gain_t;

  localparam gain_t UNITY_GAIN = 14'd1000;
  localparam gain_t MAX_GAIN   = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RAMP
  } state_t;

  function automatic logic bcd_bad(bcd_t d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/gain_mult_sat.sv
// Stage-2 datapath: wave * gain / 1000, truncated toward zero,
// then saturated to the 16-bit sample range.
module gain_mult_sat
  import level_pkg::*;
(
  input  logic signed [15:0] wave,
  input  gain_t              gain,
  output logic signed [15:0] sat_wave,
  output logic               clip
);

  logic signed [31:0] w_ext;
  logic signed [31:0] g_ext;
  logic signed [31:0] p;
  logic signed [31:0] q;

  assign w_ext = 32'(wave);
  assign g_ext = {18'd0, gain};
  assign p     = w_ext * g_ext;
  // signed division rounds toward zero
  assign q     = p / 32'sd1000;

  always_comb begin
    sat_wave = q[15:0];
    clip     = 1'b0;
    if (q > 32'sd32767) begin
      sat_wave = 16'sh7fff;
      clip     = 1'b1;
    end else if (q < -32'sd32768) begin
      sat_wave = 16'sh8000;
      clip     = 1'b1;
    end
  end

endmodule

// File: rtl/level_gain_apply.sv
// Serial BCD gain entry with per-sample ramping, applied
// to the audio stream through a two-stage pipeline.
module level_gain_apply
  import level_pkg::*;
#(
  parameter int STEP      = 8,
  parameter int INIT_GAIN = 1000
) (
  input  logic               clk_48,
  input  logic               reset_n,
  input  logic               load,
  input  bcd_t               num3,
  input  bcd_t               num2,
  input  bcd_t               num1,
  input  bcd_t               num0,
  input  logic signed [15:0] inWave,
  output logic signed [15:0] outWave,
  output logic               busy,
  output logic               bad_digit,
  output logic               clip
);

  localparam gain_t STEP_G = gain_t'(STEP);
  localparam gain_t INIT_G = gain_t'(INIT_GAIN);

  state_t             state;
  bcd_t [3:0]         digs;
  logic [1:0]         cnt;
  gain_t              acc;
  logic               err;
  gain_t              target;
  gain_t              gain;
  logic signed [15:0] s1_wave;
  gain_t              s1_gain;

  bcd_t               cur_dig;
  gain_t              acc_nxt;
  logic               err_nxt;
  gain_t              diff;
  gain_t              stp;
  gain_t              gain_nxt;
  logic signed [15:0] sat_wave;
  logic               sat_clip;

  // digs[0] holds the thousands digit so cnt walks num3 first
  assign cur_dig = digs[cnt];
  assign acc_nxt = 14'(acc * 14'd10) + {10'd0, cur_dig};
  assign err_nxt = err | bcd_bad(cur_dig);

  always_comb begin
    diff     = (target > gain) ? target - gain
                               : gain - target;
    stp      = (diff > STEP_G) ? STEP_G : diff;
    gain_nxt = (target > gain) ? gain + stp
                               : gain - stp;
  end

  gain_mult_sat u_mult (
    .wave     (s1_wave),
    .gain     (s1_gain),
    .sat_wave (sat_wave),
    .clip     (sat_clip)
  );

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      digs      <= '0;
      cnt       <= 2'd0;
      acc       <= '0;
      err       <= 1'b0;
      target    <= INIT_G;
      gain      <= INIT_G;
      busy      <= 1'b0;
      bad_digit <= 1'b0;
      s1_wave   <= '0;
      s1_gain   <= '0;
      outWave   <= '0;
      clip      <= 1'b0;
    end else begin
      s1_wave <= inWave;
      s1_gain <= gain;
      outWave <= sat_wave;
      clip    <= sat_clip;
      unique case (state)
        IDLE: begin
          if (load) begin
            digs      <= {num0, num1, num2, num3};
            cnt       <= 2'd0;
            acc       <= '0;
            err       <= 1'b0;
            bad_digit <= 1'b0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          err <= err_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (err_nxt) begin
              bad_digit <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              target <= acc_nxt;
              state  <= RAMP;
            end
          end
        end
        RAMP: begin
          gain <= gain_nxt;
          if (gain_nxt == target) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
